accel_output_stage: RTL and testbench

Parametrised post-processing stage between the systolic array's column outputs and the output buffer. It accepts one vector of LANES signed accumulators per handshake and requantises each lane with a rounding arithmetic right shift and signed saturation. It then applies a runtime-selected activation (none / ReLU / clipped ReLU) and queues the narrowed vectors in an internal FIFO behind a valid/ready interface. It replaces the fixed compile-time buffer/ReLU options with a runtime activation mode, requantisation and backpressure-safe buffering.

---
 rtl/accel_output_stage.sv | 269 ++++++++++++++++++++++++++
 tb/tb_accel_output_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_output_stage.sv
// Output post-processing stage: rounding requantise, saturate,
// runtime activation, then a credit-guarded show-ahead FIFO.
module accel_output_stage #(
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int BITWIDTH   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANES*ACC_WIDTH-1:0]      in_data,
  input  logic                            in_last,
  input  logic [4:0]                      cfg_shift,
  input  logic [1:0]                      cfg_act,
  input  logic [BITWIDTH-1:0]             cfg_clip,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES*BITWIDTH-1:0]       out_data,
  output logic                            out_last,
  output logic [$clog2(FIFO_DEPTH):0]     count,
  output logic                            sat_sticky,
  input  logic                            clr_sat
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int XW = ACC_WIDTH + 1;
  localparam int OW = LANES * BITWIDTH;

  localparam logic [CW:0] DEPTH_W =
    (CW+1)'(FIFO_DEPTH);

  localparam logic [XW-1:0] ONE_X =
    XW'(1);

  localparam logic [BITWIDTH-1:0] SAT_MAX =
    {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic [BITWIDTH-1:0] SAT_MIN =
    {1'b1, {(BITWIDTH-1){1'b0}}};

  localparam logic [1:0] ACT_RELU = 2'd1;
  localparam logic [1:0] ACT_CLIP = 2'd2;

  // ---------------- stage 1 state
  logic                       s1_valid_q;
  logic                       s1_valid_d;
  logic                       s1_last_q;
  logic                       s1_last_d;
  logic [1:0]                 s1_act_q;
  logic [1:0]                 s1_act_d;
  logic [BITWIDTH-1:0]        s1_clip_q;
  logic [BITWIDTH-1:0]        s1_clip_d;
  logic signed [XW-1:0]       s1_r_q [LANES];
  logic signed [XW-1:0]       s1_r_d [LANES];

  // stage 1 per-lane scratch
  logic signed [XW-1:0]       x_ext  [LANES];
  logic [XW-1:0]              rnd    [LANES];
  logic signed [XW-1:0]       x_sum  [LANES];

  // ---------------- stage 2 state
  logic                       s2_valid_q;
  logic                       s2_valid_d;
  logic                       s2_last_q;
  logic                       s2_last_d;
  logic [OW-1:0]              s2_data_q;
  logic [OW-1:0]              s2_data_d;

  // stage 2 per-lane scratch
  logic [XW-BITWIDTH:0]       hi_bits [LANES];
  logic                       lane_ovf [LANES];
  logic [BITWIDTH-1:0]        sat_val [LANES];
  logic [BITWIDTH-1:0]        act_val [LANES];
  logic                       any_sat;

  logic                       sat_q;
  logic                       sat_d;

  // ---------------- fifo state
  logic [OW-1:0]              fifo_data_q [FIFO_DEPTH];
  logic [OW-1:0]              fifo_data_d [FIFO_DEPTH];
  logic                       fifo_last_q [FIFO_DEPTH];
  logic                       fifo_last_d [FIFO_DEPTH];
  logic [PW-1:0]              wptr_q;
  logic [PW-1:0]              wptr_d;
  logic [PW-1:0]              rptr_q;
  logic [PW-1:0]              rptr_d;
  logic [CW-1:0]              count_q;
  logic [CW-1:0]              count_d;

  logic                       accept;
  logic                       fifo_wr;
  logic                       fifo_pop;
  logic [CW:0]                credit_used;

  // Credits count the FIFO plus everything in flight,
  // so S2 can always write without checking for space.
  always_comb begin
    credit_used = (CW+1)'(count_q)
                + (CW+1)'(s1_valid_q)
                + (CW+1)'(s2_valid_q);
    in_ready    = ~rst & (credit_used < DEPTH_W);
    accept      = in_valid & in_ready;
    fifo_wr     = s2_valid_q;
    out_valid   = (count_q != '0);
    fifo_pop    = out_valid & out_ready;
  end

  // Stage 1: sign-extend, add half-LSB, arithmetic shift.
  always_comb begin
    s1_valid_d = accept;
    s1_last_d  = s1_last_q;
    s1_act_d   = s1_act_q;
    s1_clip_d  = s1_clip_q;
    for (int i = 0; i < LANES; i++) begin
      x_ext[i] = signed'({
        in_data[i*ACC_WIDTH+ACC_WIDTH-1],
        in_data[i*ACC_WIDTH +: ACC_WIDTH]
      });
      if (cfg_shift == 5'd0) begin
        rnd[i] = '0;
      end else begin
        rnd[i] = ONE_X << (cfg_shift - 5'd1);
      end
      x_sum[i]  = x_ext[i] + signed'(rnd[i]);
      s1_r_d[i] = s1_r_q[i];
    end
    if (accept) begin
      s1_last_d = in_last;
      s1_act_d  = cfg_act;
      s1_clip_d = cfg_clip;
      for (int i = 0; i < LANES; i++) begin
        s1_r_d[i] = x_sum[i] >>> cfg_shift;
      end
    end
  end

  // Stage 2: clamp each lane, then the activation.
  always_comb begin
    any_sat    = 1'b0;
    s2_valid_d = s1_valid_q;
    s2_last_d  = s2_last_q;
    s2_data_d  = s2_data_q;
    for (int i = 0; i < LANES; i++) begin
      hi_bits[i]  = s1_r_q[i][XW-1:BITWIDTH-1];
      lane_ovf[i] = ~((&hi_bits[i]) | ~(|hi_bits[i]));
      if (lane_ovf[i]) begin
        sat_val[i] = s1_r_q[i][XW-1] ? SAT_MIN
                                     : SAT_MAX;
      end else begin
        sat_val[i] = s1_r_q[i][BITWIDTH-1:0];
      end
      any_sat    = any_sat | lane_ovf[i];
      act_val[i] = sat_val[i];
      case (s1_act_q)
        ACT_RELU: begin
          if (sat_val[i][BITWIDTH-1]) begin
            act_val[i] = '0;
          end
        end
        ACT_CLIP: begin
          if (sat_val[i][BITWIDTH-1]) begin
            act_val[i] = '0;
          end else if (sat_val[i] > s1_clip_q) begin
            act_val[i] = s1_clip_q;
          end
        end
        default: begin
          act_val[i] = sat_val[i];
        end
      endcase
    end
    if (s1_valid_q) begin
      s2_last_d = s1_last_q;
      for (int i = 0; i < LANES; i++) begin
        s2_data_d[i*BITWIDTH +: BITWIDTH] = act_val[i];
      end
    end
  end

  // Sticky saturation flag; a new event beats a clear.
  always_comb begin
    sat_d = sat_q & ~clr_sat;
    if (s1_valid_q & any_sat) begin
      sat_d = 1'b1;
    end
  end

  // FIFO write/pop bookkeeping; pointers wrap by width.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    if (fifo_wr) begin
      fifo_data_d[wptr_q] = s2_data_q;
      fifo_last_d[wptr_q] = s2_last_q;
      wptr_d              = wptr_q + PW'(1);
    end
    if (fifo_pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    unique case ({fifo_wr, fifo_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_act_q   <= '0;
      s1_clip_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_data_q  <= '0;
      sat_q      <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        s1_r_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_act_q   <= s1_act_d;
      s1_clip_q  <= s1_clip_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      s2_data_q  <= s2_data_d;
      sat_q      <= sat_d;
      for (int i = 0; i < LANES; i++) begin
        s1_r_q[i] <= s1_r_d[i];
      end
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
    end
  end

  // Show-ahead head of the FIFO.
  always_comb begin
    out_data   = fifo_data_q[rptr_q];
    out_last   = fifo_last_q[rptr_q];
    count      = count_q;
    sat_sticky = sat_q;
  end

endmodule

// File: tb/tb_accel_output_stage.sv
// Directed bench for accel_output_stage: vector table
// plus backpressure, per-beat config and reset sequences.
module tb_accel_output_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_last;
  logic [4:0]   cfg_shift;
  logic [1:0]   cfg_act;
  logic [7:0]   cfg_clip;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic [2:0]   count;
  logic         sat_sticky;
  logic         clr_sat;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [127:0] data;
    logic [4:0]   sh;
    logic [1:0]   act;
    logic [7:0]   clip;
    logic         last;
    logic [31:0]  exp;
    logic         exp_sat;
  } vec_t;

  vec_t tbl [9];

  accel_output_stage #(
    .LANES(4), .ACC_WIDTH(32),
    .BITWIDTH(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .cfg_shift(cfg_shift), .cfg_act(cfg_act),
    .cfg_clip(cfg_clip),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .count(count), .sat_sticky(sat_sticky),
    .clr_sat(clr_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  function automatic logic [127:0] pack4(
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] bp_exp(input int k);
    logic [7:0] b;
    b = 8'(k * 10);
    return {b + 8'd4, b + 8'd3, b + 8'd2, b + 8'd1};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_data   = v.data;
    cfg_shift = v.sh;
    cfg_act   = v.act;
    cfg_clip  = v.clip;
    in_last   = v.last;
  endtask

  // One isolated beat through an empty pipe.
  task automatic xfer(input vec_t v, input bit clr_mid,
                      input string nm);
    int k;
    @(negedge clk);
    clr_sat = 1'b1;
    @(negedge clk);
    clr_sat = 1'b0;
    chk({nm, "_preclr"}, 64'(sat_sticky), 64'd0);
    drive(v);
    in_valid = 1'b1;
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    clr_sat  = clr_mid;
    k = 1;
    while (!out_valid && k < 12) begin
      @(negedge clk);
      clr_sat = 1'b0;
      k++;
    end
    clr_sat = 1'b0;
    chk({nm, "_lat"}, 64'(k), 64'd3);
    chk({nm, "_data"},
        {31'd0, out_last, out_data},
        {31'd0, v.last, v.exp});
    chk({nm, "_sat"}, 64'(sat_sticky), 64'(v.exp_sat));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_empty"}, {count, out_valid}, 64'd0);
  endtask

  initial begin
    vec_t v;
    vec_t va;
    vec_t vb;
    int sent;
    int rcv;
    bit acc;
    bit pop;
    bit stale;

    tbl[0] = '{pack4(296, -40, 8, 2047), 5'd4,
               2'd0, 8'd0, 1'b0, 32'h7F01FE13, 1'b1};
    tbl[1] = '{pack4(296, -40, 8, 2047), 5'd4,
               2'd1, 8'd0, 1'b1, 32'h7F010013, 1'b1};
    tbl[2] = '{pack4(296, -40, 8, 2047), 5'd4,
               2'd2, 8'd6, 1'b0, 32'h06010006, 1'b1};
    tbl[3] = '{pack4(-200, 127, -128, 128), 5'd0,
               2'd0, 8'd0, 1'b1, 32'h7F807F80, 1'b1};
    tbl[4] = '{pack4(5, -5, 6, -6), 5'd1,
               2'd3, 8'd0, 1'b0, 32'hFD03FE03, 1'b0};
    tbl[5] = '{pack4(5, -6, 1020, -512), 5'd2,
               2'd0, 8'd0, 1'b1, 32'h807FFF01, 1'b1};
    tbl[6] = '{pack4(32'h40000000, 32'h80000000,
                     32'h7FFFFFFF, 32'hBFFFFFFF), 5'd31,
               2'd0, 8'd0, 1'b0, 32'hFF01FF01, 1'b0};
    tbl[7] = '{pack4(100, -3, 127, 50), 5'd0,
               2'd2, 8'd200, 1'b1, 32'h327F0064, 1'b0};
    tbl[8] = '{pack4(-1, 0, 1, -128), 5'd0,
               2'd1, 8'd0, 1'b0, 32'h00010000, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    cfg_shift = '0;
    cfg_act   = '0;
    cfg_clip  = '0;
    out_ready = 1'b0;
    clr_sat   = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_state",
        {out_last, out_data, count, out_valid, sat_sticky},
        64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 9; i++) begin
      xfer(tbl[i], 1'b0, $sformatf("vec%0d", i));
    end

    // clear coincident with saturation: set wins
    xfer(tbl[3], 1'b1, "clr_vs_sat");
    @(negedge clk);
    clr_sat = 1'b1;
    @(negedge clk);
    clr_sat = 1'b0;
    chk("clr_later", 64'(sat_sticky), 64'd0);

    // per-beat shift change, back to back
    va = '{pack4(5, 5, 5, 5), 5'd1, 2'd0, 8'd0,
           1'b1, 32'h03030303, 1'b0};
    vb = '{pack4(5, 5, 5, 5), 5'd2, 2'd0, 8'd0,
           1'b0, 32'h01010101, 1'b0};
    out_ready = 1'b1;
    @(negedge clk);
    drive(va);
    in_valid = 1'b1;
    @(negedge clk);
    drive(vb);
    @(negedge clk);
    in_valid = 1'b0;
    rcv = 0;
    for (int c = 0; c < 10 && rcv < 2; c++) begin
      if (out_valid) begin
        v = (rcv == 0) ? va : vb;
        chk($sformatf("cfg_beat%0d", rcv),
            {31'd0, out_last, out_data},
            {31'd0, v.last, v.exp});
        rcv++;
      end
      @(negedge clk);
    end
    chk("cfg_beat_cnt", 64'(rcv), 64'd2);
    out_ready = 1'b0;

    // backpressure: 6 offered, 4 fit
    sent = 0;
    cfg_shift = 5'd0;
    cfg_act   = 2'd0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = (sent < 6);
      in_data  = pack4(sent*10+1, sent*10+2,
                       sent*10+3, sent*10+4);
      in_last  = sent[0];
      acc = in_valid & in_ready;
      @(posedge clk);
      if (acc) sent++;
    end
    @(negedge clk);
    chk("bp_accepted", 64'(sent), 64'd4);
    chk("bp_full", {count, in_ready}, {3'd4, 1'b0});
    out_ready = 1'b1;
    rcv = 0;
    for (int c = 0; c < 40 && rcv < 6; c++) begin
      if (c != 0) @(negedge clk);
      in_valid = (sent < 6);
      in_data  = pack4(sent*10+1, sent*10+2,
                       sent*10+3, sent*10+4);
      in_last  = sent[0];
      acc = in_valid & in_ready;
      pop = out_valid;
      if (pop) begin
        chk($sformatf("bp_out%0d", rcv),
            {31'd0, out_last, out_data},
            {31'd0, rcv[0], bp_exp(rcv)});
      end
      @(posedge clk);
      if (acc) sent++;
      if (pop) rcv++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_totals", {32'(sent), 32'(rcv)},
        {32'd6, 32'd6});

    // reset with 2 queued and 1 in S1
    out_ready = 1'b0;
    in_data   = pack4(1, 2, 3, 4);
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("prerst_count", 64'(count), 64'd2);
    rst = 1'b1;
    #1;
    chk("async_rst",
        {count, out_valid, in_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 8; c++) begin
      if (out_valid) stale = 1'b1;
      @(negedge clk);
    end
    chk("no_stale", {stale, count}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
